lfsr_burst_ctrl: RTL

Sequencing controller that owns the 8-bit Fibonacci LFSR state register and doles out pseudo-random words to one downstream consumer.
- Supports seed loading, start of a counted burst, abort, and a valid/ready output handshake.
- Register advances only on an accepted word.
- Feedback taps and shift order match the existing lfsr81False, so both produce identical sequences from the same seed.
- Sits between the test/config bus and any PRBS consumer (BIST pattern source, scrambler).

---
 rtl/lfsr_burst_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lfsr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_burst_ctrl
//
// Sequencing controller that owns an 8-bit Fibonacci LFSR state register and
// hands pseudo-random words to a single downstream consumer over a
// valid/ready handshake. The register advances only when a word is accepted.
// The feedback taps and shift order match lfsr81False, so both blocks produce
// identical sequences from the same seed.
//
// Feedback polynomial x^8+x^6+x^5+x^4+1 (period 255):
//   fb = s[7]^s[5]^s[4]^s[3];  next = {s[6:0], fb}
//
// Parameters:
//   CNT_W     width of the burst length and remaining-word counter
//   SEED_RST  LFSR state after reset (must be nonzero)
//
// Ports:
//   CLK        in   1      clock, all state updates on the rising edge
//   RESET      in   1      synchronous, active-low reset
//   cfg_seed   in   8      seed value used by cfg_load
//   cfg_load   in   1      load seed (honoured in IDLE only)
//   start      in   1      begin a burst (honoured in IDLE only)
//   burst_len  in   CNT_W  words in the burst, sampled with start
//   stop       in   1      abort a running burst
//   out_valid  out  1      out_data holds a word for the consumer
//   out_ready  in   1      consumer accepts the word
//   out_data   out  8      current LFSR state
//   busy       out  1      controller not idle
//   done       out  1      one-cycle pulse, burst completed normally
//   aborted    out  1      one-cycle pulse, burst ended by stop
//   seed_fix   out  1      sticky flag, a zero seed was replaced by 8'h01
// ---------------------------------------------------------------------------
module lfsr_burst_ctrl #(
   parameter int         CNT_W    = 16,
   parameter logic [7:0] SEED_RST = 8'h01
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [7:0]       cfg_seed,
   input  logic             cfg_load,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             stop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             seed_fix
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // An all-zero LFSR would lock up, so a zero reset seed is forced to 8'h01.
   localparam logic [7:0]       SEED_SAFE = (SEED_RST == 8'h00) ? 8'h01 : SEED_RST;
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // One Fibonacci step of the x^8+x^6+x^5+x^4+1 register.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   state_e           state_q, state_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             fix_q, fix_d;
   logic             hs_s;

   // A word is transferred when the presented word is accepted.
   assign hs_s = valid_q & out_ready;

   // Next-state, counter, LFSR and pulse computation.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      rem_d     = rem_q;
      fix_d     = fix_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Seed load and start may coincide; the burst then begins from
            // the freshly loaded seed.
            if (cfg_load) begin
               if (cfg_seed == 8'h00) begin
                  lfsr_d = 8'h01;
                  fix_d  = 1'b1;
               end else begin
                  lfsr_d = cfg_seed;
               end
            end else begin
               lfsr_d = lfsr_q;
            end

            // A zero-length start is silently dropped.
            if (start && (burst_len != CNT_ZERO)) begin
               rem_d   = burst_len;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (hs_s) begin
               lfsr_d = lfsr_step(lfsr_q);
               if (rem_q != CNT_ZERO) begin
                  rem_d = rem_q - CNT_ONE;
               end else begin
                  rem_d = CNT_ZERO;
               end
               // Completion takes priority over a coincident stop.
               if (rem_q == CNT_ONE) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (stop) begin
                  state_d   = ST_IDLE;
                  aborted_d = 1'b1;
                  rem_d     = CNT_ZERO;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (stop) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
               rem_d     = CNT_ZERO;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            rem_d   = CNT_ZERO;
         end
      endcase

      // Status outputs are registered copies derived from the next state.
      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= SEED_SAFE;
         rem_q     <= CNT_ZERO;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         fix_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         rem_q     <= rem_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         fix_q     <= fix_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = lfsr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign seed_fix  = fix_q;

endmodule
